gerenciador_atributos: RTL and testbench
========================================

# gerenciador_atributos

- Produces the three 8-bit pet attributes consumed by the state controller: `fome`, `felicidade` and `sono`. A value of 0 means critical.
- Reads the controller's `estado` and advances every attribute once per prescaled tick. Each attribute rises or decays with saturation, according to the activity in progress.
- Sits beside the state controller in the Tamagotchi top level and closes the feedback loop: estado → attributes → estado.

## Interface
- `TICK_DIV`, default 16'd50000: clock cycles per attribute tick; legal range 1..65535.
- `INIT`, default 8'd200: value loaded into every attribute on reset.
- `GAIN`, default 8'd4: per-tick increase of the attribute being restored.
- `DECAY`, default 8'd1: per-tick decrease of an idle attribute.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `estado` input 4: activity code. IDLE=0000, DORMINDO=0001, COMENDO=0010, DANDO_AULA=0100, MORTO=1000.
- `fome` output 8: satiation level; 0 = starving.
- `felicidade` output 8: happiness level.
- `sono` output 8: rest level.
- `tick` output 1: one-cycle pulse on the cycle the attributes update.
- `morto` output 1: death flag. Active only with ATTR_MORTE_EN; otherwise constant 0.

## Operation
- Prescaler is a 16-bit counter.
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - `tick` = 1 while the counter equals TICK_DIV-1.
  - TICK_DIV=1 gives a tick every cycle.
  - Free-running; a change of estado does not restart it.
- On each tick, `estado` is sampled and each attribute is updated:
  - IDLE: fome −DECAY, felicidade −DECAY, sono −DECAY.
  - COMENDO: fome +GAIN, felicidade −DECAY, sono −DECAY.
  - DORMINDO: sono +GAIN, fome −DECAY, felicidade unchanged.
  - DANDO_AULA: felicidade +GAIN, fome −DECAY, sono −2·DECAY.
  - MORTO: all attributes hold.
  - Any other code (including multi-hot): treated as IDLE.
- Arithmetic:
  - Computed in 9 bits.
  - Additions saturate at 255; subtractions saturate at 0.
  - The 2·DECAY term is formed in 9 bits before saturation.
- Between ticks, all attributes hold.

## Timing
- Reset values:
  - fome = felicidade = sono = INIT.
  - tick = 0, morto = 0.
  - Prescaler = 0.
- Reset is asynchronous on assertion. After release, the first tick occurs on the TICK_DIV-th rising edge.
- Latency:
  - Attributes update on the rising edge that ends the tick cycle; the new values are visible the cycle after `tick` = 1.
  - estado is sampled at that same edge, so a change landing on the tick cycle takes effect immediately.
- Saturation boundaries:
  - 254 + 4 → 255; 255 + 4 → 255.
  - 1 − 1 → 0; 0 − 1 → 0.
  - 1 − 2 → 0.
- Reset mid-count clears the prescaler and restores INIT. A partial tick period is discarded.
- All outputs are registered; there are no combinational paths from estado.

## Configuration
- Macro: ATTR_MORTE_EN.
- Defined:
  - On a tick, if any post-update attribute equals 0, `morto` is set on that edge.
  - `morto` stays set until rst_n, and all attributes freeze while it is set, regardless of estado.
- Undefined:
  - `morto` is tied to 0.
  - Attributes stay pinned at 0 by saturation and keep responding to estado.

## Structure
- Shared package `tamagotchi_pkg` holds:
  - the five estado codes (IDLE, DORMINDO, COMENDO, DANDO_AULA, MORTO);
  - the attribute width constant (8).
- The controller and this block both import the package.
- One sub-module, `saturador`: 8-bit value plus 9-bit signed delta → saturated 8-bit result. Instantiated three times, once per attribute.
- The prescaler and per-state delta selection stay inline.

## Test plan
- Bench uses TICK_DIV=4, INIT=200, GAIN=4, DECAY=1.
- Reset then IDLE for 3 ticks → fome=felicidade=sono=197. `tick` period is 4 cycles; first pulse on cycle 4 after release.
- COMENDO from fome=253 for 2 ticks → fome 255 then 255 (saturated). sono decreases by 1 per tick.
- DANDO_AULA from sono=3 for 2 ticks → sono 1 then 0; felicidade +4 each tick.
- estado switched IDLE→DORMINDO on the tick cycle itself → that update already uses DORMINDO: sono +4, felicidade unchanged.
- Illegal estado=4'b0011 for 1 tick → all attributes −1, same as IDLE. rst_n pulsed mid-period → INIT restored; next tick after a full 4 cycles.
- With ATTR_MORTE_EN, fome driven to 0 → `morto` = 1 the cycle after the tick. Attributes then frozen under COMENDO for 3 ticks; `morto` cleared only by rst_n.

Source files
------------

// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the Tamagotchi core: activity codes driven by the
// state controller and the width of every pet attribute.
package tamagotchi_pkg;

    localparam int ATTR_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'b0000,
        ST_DORMINDO   = 4'b0001,
        ST_COMENDO    = 4'b0010,
        ST_DANDO_AULA = 4'b0100,
        ST_MORTO      = 4'b1000
    } estado_t;

endpackage

// File: rtl/gerenciador_atributos_saturador.sv
// saturador: applies a signed 9-bit delta to an 8-bit attribute and clamps
// the result to 0..255. Purely combinational; the caller registers it.
module saturador
    import tamagotchi_pkg::*;
(
    input  logic [ATTR_W-1:0] valor,
    input  logic signed [8:0] delta,
    output logic [ATTR_W-1:0] resultado
);

    // One extra bit over the 9-bit delta so value+delta (-256..510) never wraps.
    logic signed [9:0] soma;

    assign soma = $signed({2'b00, valor}) + $signed({delta[8], delta});

    // Clamp: negative sums pin to 0, sums above 255 pin to 255.
    always_comb begin
        resultado = soma[ATTR_W-1:0];
        if (soma[9]) begin
            resultado = '0;
        end else if (soma > 10'sd255) begin
            resultado = '1;
        end
    end

endmodule

// File: rtl/gerenciador_atributos.sv
// gerenciador_atributos: keeps the pet attributes fome, felicidade and sono.
// A free-running prescaler emits a one-cycle tick every TICK_DIV cycles; on
// the edge that ends the tick cycle each attribute moves by a delta chosen
// from estado, saturating at 0 and 255.
// Optional feature macro: ATTR_MORTE_EN (sticky death flag that freezes the
// attributes once any of them reaches 0 on a tick).
module gerenciador_atributos
    import tamagotchi_pkg::*;
#(
    parameter logic [15:0]       TICK_DIV = 16'd50000,
    parameter logic [ATTR_W-1:0] INIT     = 8'd200,
    parameter logic [ATTR_W-1:0] GAIN     = 8'd4,
    parameter logic [ATTR_W-1:0] DECAY    = 8'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        estado,
    output logic [ATTR_W-1:0] fome,
    output logic [ATTR_W-1:0] felicidade,
    output logic [ATTR_W-1:0] sono,
    output logic              tick,
    output logic              morto
);

    localparam logic [15:0] TICK_LAST = TICK_DIV - 16'd1;

    // Signed deltas. 2*DECAY is built in 9 bits; if it exceeds 255 its
    // negation no longer fits, but -256 already drives any value to 0.
    localparam logic signed [8:0] D_GAIN  = $signed({1'b0, GAIN});
    localparam logic signed [8:0] D_DEC   = 9'sd0 - $signed({1'b0, DECAY});
    localparam logic        [8:0] DEC2    = {DECAY, 1'b0};
    localparam logic signed [8:0] D_DEC2  = (DEC2 > 9'd255) ? -9'sd256
                                                            : 9'sd0 - $signed(DEC2);
    localparam logic signed [8:0] D_HOLD  = 9'sd0;

    logic [15:0]       cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [ATTR_W-1:0] fome_q, fome_d;
    logic [ATTR_W-1:0] felicidade_q, felicidade_d;
    logic [ATTR_W-1:0] sono_q, sono_d;

    logic signed [8:0] delta_fome, delta_felicidade, delta_sono;
    logic [ATTR_W-1:0] fome_sat, felicidade_sat, sono_sat;
    logic              congelado;

    // Prescaler: wraps at TICK_DIV-1; tick is registered and high while the
    // counter sits on its last value.
    always_comb begin
        cnt_d  = (cnt_q == TICK_LAST) ? 16'd0 : cnt_q + 16'd1;
        tick_d = (cnt_d == TICK_LAST);
    end

    // Per-activity delta selection; unknown and multi-hot codes behave as IDLE.
    always_comb begin
        delta_fome       = D_DEC;
        delta_felicidade = D_DEC;
        delta_sono       = D_DEC;
        case (estado)
            ST_COMENDO: begin
                delta_fome = D_GAIN;
            end
            ST_DORMINDO: begin
                delta_sono       = D_GAIN;
                delta_felicidade = D_HOLD;
            end
            ST_DANDO_AULA: begin
                delta_felicidade = D_GAIN;
                delta_sono       = D_DEC2;
            end
            ST_MORTO: begin
                delta_fome       = D_HOLD;
                delta_felicidade = D_HOLD;
                delta_sono       = D_HOLD;
            end
            default: ;
        endcase
    end

    saturador u_sat_fome (
        .valor     (fome_q),
        .delta     (delta_fome),
        .resultado (fome_sat)
    );

    saturador u_sat_felicidade (
        .valor     (felicidade_q),
        .delta     (delta_felicidade),
        .resultado (felicidade_sat)
    );

    saturador u_sat_sono (
        .valor     (sono_q),
        .delta     (delta_sono),
        .resultado (sono_sat)
    );

`ifdef ATTR_MORTE_EN
    logic morto_q, morto_d;

    // Death flag: set when any post-update attribute hits 0 on a tick,
    // cleared only by reset.
    always_comb begin
        morto_d = morto_q;
        if (tick_q && !morto_q &&
            ((fome_sat == '0) || (felicidade_sat == '0) || (sono_sat == '0))) begin
            morto_d = 1'b1;
        end
    end

    // Death flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            morto_q <= 1'b0;
        end else begin
            morto_q <= morto_d;
        end
    end

    assign congelado = morto_q;
    assign morto     = morto_q;
`else
    assign congelado = 1'b0;
    assign morto     = 1'b0;
`endif

    // Attribute next-state: move only on a tick and only while not frozen.
    always_comb begin
        fome_d       = fome_q;
        felicidade_d = felicidade_q;
        sono_d       = sono_q;
        if (tick_q && !congelado) begin
            fome_d       = fome_sat;
            felicidade_d = felicidade_sat;
            sono_d       = sono_sat;
        end
    end

    // State registers for prescaler, tick and attributes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= 16'd0;
            tick_q       <= 1'b0;
            fome_q       <= INIT;
            felicidade_q <= INIT;
            sono_q       <= INIT;
        end else begin
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            fome_q       <= fome_d;
            felicidade_q <= felicidade_d;
            sono_q       <= sono_d;
        end
    end

    assign fome       = fome_q;
    assign felicidade = felicidade_q;
    assign sono       = sono_q;
    assign tick       = tick_q;

endmodule

// File: tb/tb_gerenciador_atributos.sv
// Directed bench for gerenciador_atributos with TICK_DIV=4, INIT=200,
// GAIN=4, DECAY=1. Outputs are sampled on the falling edge.
module tb_gerenciador_atributos;
  import tamagotchi_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] estado;
  logic [7:0] fome, felicidade, sono;
  logic       tick, morto;

  int checks = 0;
  int errors = 0;

  gerenciador_atributos #(
    .TICK_DIV (16'd4),
    .INIT     (8'd200),
    .GAIN     (8'd4),
    .DECAY    (8'd1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .estado     (estado),
    .fome       (fome),
    .felicidade (felicidade),
    .sono       (sono),
    .tick       (tick),
    .morto      (morto)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // wait for the next tick cycle, then step past the updating edge
  task automatic wait_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) begin
      checks++; errors++;
      $display("FAIL tick_timeout: tick=%b after %0d cycles, want 1", tick, n);
    end
    @(negedge clk);
  endtask

  task automatic run_ticks(input logic [3:0] st, input int n);
    estado = st;
    repeat (n) wait_tick();
  endtask

  task automatic test_reset();
    int n = 0;
    rst_n  = 1'b0;
    estado = ST_IDLE;
    repeat (2) @(negedge clk);
    checks++; if (fome !== 8'd200) begin errors++; $display("FAIL rst_fome: got %0d want 200", fome); end
    checks++; if (felicidade !== 8'd200) begin errors++; $display("FAIL rst_felicidade: got %0d want 200", felicidade); end
    checks++; if (sono !== 8'd200) begin errors++; $display("FAIL rst_sono: got %0d want 200", sono); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b want 0", tick); end
    checks++; if (morto !== 1'b0) begin errors++; $display("FAIL rst_morto: got %b want 0", morto); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL first_tick_e1: got %b want 0", tick); end
    @(negedge clk);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL first_tick_e2: got %b want 0", tick); end
    @(negedge clk);
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL first_tick_e3: got %b want 1", tick); end
    @(negedge clk);
    checks++; if (fome !== 8'd199) begin errors++; $display("FAIL idle1_fome: got %0d want 199", fome); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_one_cycle: got %b want 0", tick); end
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL tick_period: got %0d want 4", n + 1); end
    @(negedge clk);
    wait_tick();
    checks++; if (fome !== 8'd197) begin errors++; $display("FAIL idle3_fome: got %0d want 197", fome); end
    checks++; if (felicidade !== 8'd197) begin errors++; $display("FAIL idle3_felicidade: got %0d want 197", felicidade); end
    checks++; if (sono !== 8'd197) begin errors++; $display("FAIL idle3_sono: got %0d want 197", sono); end
  endtask

  task automatic test_comendo();
    run_ticks(ST_COMENDO, 14);
    checks++; if (fome !== 8'd253) begin errors++; $display("FAIL com_pre_fome: got %0d want 253", fome); end
    wait_tick();
    checks++; if (fome !== 8'd255) begin errors++; $display("FAIL com_sat1_fome: got %0d want 255", fome); end
    checks++; if (sono !== 8'd182) begin errors++; $display("FAIL com_sat1_sono: got %0d want 182", sono); end
    wait_tick();
    checks++; if (fome !== 8'd255) begin errors++; $display("FAIL com_sat2_fome: got %0d want 255", fome); end
    checks++; if (sono !== 8'd181) begin errors++; $display("FAIL com_sat2_sono: got %0d want 181", sono); end
    checks++; if (felicidade !== 8'd181) begin errors++; $display("FAIL com_sat2_felicidade: got %0d want 181", felicidade); end
  endtask

  task automatic test_dando_aula();
    run_ticks(ST_IDLE, 170);
    checks++; if (fome !== 8'd85) begin errors++; $display("FAIL idle170_fome: got %0d want 85", fome); end
    checks++; if (sono !== 8'd11) begin errors++; $display("FAIL idle170_sono: got %0d want 11", sono); end
    run_ticks(ST_DANDO_AULA, 4);
    checks++; if (sono !== 8'd3) begin errors++; $display("FAIL aula4_sono: got %0d want 3", sono); end
    checks++; if (felicidade !== 8'd27) begin errors++; $display("FAIL aula4_felicidade: got %0d want 27", felicidade); end
    checks++; if (fome !== 8'd81) begin errors++; $display("FAIL aula4_fome: got %0d want 81", fome); end
    wait_tick();
    checks++; if (sono !== 8'd1) begin errors++; $display("FAIL aula5_sono: got %0d want 1", sono); end
    checks++; if (felicidade !== 8'd31) begin errors++; $display("FAIL aula5_felicidade: got %0d want 31", felicidade); end
    wait_tick();
    checks++; if (sono !== 8'd0) begin errors++; $display("FAIL aula6_sono: got %0d want 0", sono); end
    checks++; if (felicidade !== 8'd35) begin errors++; $display("FAIL aula6_felicidade: got %0d want 35", felicidade); end
    checks++; if (fome !== 8'd79) begin errors++; $display("FAIL aula6_fome: got %0d want 79", fome); end
  endtask

  task automatic test_switch_on_tick();
    int n = 0;
    estado = ST_IDLE;
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL switch_tick_seen: got %b want 1", tick); end
    estado = ST_DORMINDO;
    @(negedge clk);
    checks++; if (sono !== 8'd4) begin errors++; $display("FAIL switch_sono: got %0d want 4", sono); end
    checks++; if (felicidade !== 8'd35) begin errors++; $display("FAIL switch_felicidade: got %0d want 35", felicidade); end
    checks++; if (fome !== 8'd78) begin errors++; $display("FAIL switch_fome: got %0d want 78", fome); end
  endtask

  task automatic test_illegal();
    run_ticks(4'b0011, 1);
    checks++; if (fome !== 8'd77) begin errors++; $display("FAIL illegal_fome: got %0d want 77", fome); end
    checks++; if (felicidade !== 8'd34) begin errors++; $display("FAIL illegal_felicidade: got %0d want 34", felicidade); end
    checks++; if (sono !== 8'd3) begin errors++; $display("FAIL illegal_sono: got %0d want 3", sono); end
  endtask

  task automatic test_reset_mid();
    estado = ST_IDLE;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (fome !== 8'd200) begin errors++; $display("FAIL midrst_fome: got %0d want 200", fome); end
    checks++; if (felicidade !== 8'd200) begin errors++; $display("FAIL midrst_felicidade: got %0d want 200", felicidade); end
    checks++; if (sono !== 8'd200) begin errors++; $display("FAIL midrst_sono: got %0d want 200", sono); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL midrst_e1: got %b want 0", tick); end
    @(negedge clk);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL midrst_e2: got %b want 0", tick); end
    @(negedge clk);
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL midrst_e3: got %b want 1", tick); end
    @(negedge clk);
    checks++; if (fome !== 8'd199) begin errors++; $display("FAIL midrst_idle_fome: got %0d want 199", fome); end
  endtask

  task automatic test_morte();
    run_ticks(ST_DORMINDO, 198);
    checks++; if (fome !== 8'd1) begin errors++; $display("FAIL dorm198_fome: got %0d want 1", fome); end
    checks++; if (sono !== 8'd255) begin errors++; $display("FAIL dorm198_sono: got %0d want 255", sono); end
    checks++; if (felicidade !== 8'd199) begin errors++; $display("FAIL dorm198_felicidade: got %0d want 199", felicidade); end
    checks++; if (morto !== 1'b0) begin errors++; $display("FAIL dorm198_morto: got %b want 0", morto); end
    wait_tick();
    checks++; if (fome !== 8'd0) begin errors++; $display("FAIL dorm199_fome: got %0d want 0", fome); end
`ifdef ATTR_MORTE_EN
    checks++; if (morto !== 1'b1) begin errors++; $display("FAIL morte_set: got %b want 1", morto); end
    run_ticks(ST_COMENDO, 3);
    checks++; if (fome !== 8'd0) begin errors++; $display("FAIL frozen_fome: got %0d want 0", fome); end
    checks++; if (felicidade !== 8'd199) begin errors++; $display("FAIL frozen_felicidade: got %0d want 199", felicidade); end
    checks++; if (sono !== 8'd255) begin errors++; $display("FAIL frozen_sono: got %0d want 255", sono); end
    checks++; if (morto !== 1'b1) begin errors++; $display("FAIL morte_sticky: got %b want 1", morto); end
    rst_n = 1'b0;
    #1;
    checks++; if (morto !== 1'b0) begin errors++; $display("FAIL morte_rst: got %b want 0", morto); end
    checks++; if (fome !== 8'd200) begin errors++; $display("FAIL morte_rst_fome: got %0d want 200", fome); end
    @(negedge clk);
    rst_n = 1'b1;
`else
    checks++; if (morto !== 1'b0) begin errors++; $display("FAIL morto_tied: got %b want 0", morto); end
    wait_tick();
    checks++; if (fome !== 8'd0) begin errors++; $display("FAIL pinned_fome: got %0d want 0", fome); end
    run_ticks(ST_COMENDO, 1);
    checks++; if (fome !== 8'd4) begin errors++; $display("FAIL revive_fome: got %0d want 4", fome); end
    checks++; if (felicidade !== 8'd198) begin errors++; $display("FAIL revive_felicidade: got %0d want 198", felicidade); end
    checks++; if (sono !== 8'd254) begin errors++; $display("FAIL revive_sono: got %0d want 254", sono); end
    checks++; if (morto !== 1'b0) begin errors++; $display("FAIL revive_morto: got %b want 0", morto); end
`endif
  endtask

  initial begin
    rst_n  = 1'b0;
    estado = ST_IDLE;
    test_reset();
    test_comendo();
    test_dando_aula();
    test_switch_on_tick();
    test_illegal();
    test_reset_mid();
    test_morte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
